// File: rtl/board_mem_arbiter.sv
// board_mem_arbiter: schedules the single board BRAM port between the renderer,
// a cursor-toggle read-modify-write and the generation-update engine.
module board_mem_arbiter #(
    parameter int WORD_SIZE     = 32,
    parameter int LOG_WORD_SIZE = 5,
    parameter int LOG_MAX_ADDR  = 12,
    parameter int READ_LATENCY  = 2
) (
    input  logic                     clk_130mhz,
    input  logic                     rst_in,
    input  logic                     render_done_in,
    input  logic [LOG_MAX_ADDR-1:0]  render_addr_in,
    input  logic                     upd_req_in,
    input  logic                     upd_we_in,
    input  logic [LOG_MAX_ADDR-1:0]  upd_addr_in,
    input  logic [WORD_SIZE-1:0]     upd_wdata_in,
    output logic                     upd_gnt_out,
    output logic                     upd_rvalid_out,
    input  logic                     edit_req_in,
    input  logic [LOG_MAX_ADDR-1:0]  edit_addr_in,
    input  logic [LOG_WORD_SIZE-1:0] edit_bit_in,
    output logic                     edit_ack_out,
    output logic [LOG_MAX_ADDR-1:0]  mem_addr_out,
    output logic                     mem_we_out,
    output logic [WORD_SIZE-1:0]     mem_wdata_out,
    input  logic [WORD_SIZE-1:0]     mem_rdata_in,
    output logic [WORD_SIZE-1:0]     mem_rdata_out
);
    typedef enum logic [2:0] {RENDER, EDIT_RD, EDIT_WAIT, EDIT_WR, UPDATE} state_t;

    localparam logic [1:0]           WAIT_LAST = 2'(READ_LATENCY > 1 ? READ_LATENCY - 2 : 0);
    localparam logic [WORD_SIZE-1:0] MSB       = {1'b1, {(WORD_SIZE-1){1'b0}}};

    state_t                   state, state_nxt;
    logic                     pend, renew;
    logic [LOG_MAX_ADDR-1:0]  pend_addr, work_addr;
    logic [LOG_WORD_SIZE-1:0] pend_bit, work_bit;
    logic [1:0]               wait_cnt;
    logic [READ_LATENCY-1:0]  rd_pipe;
    logic                     upd_rd;

    assign upd_gnt_out    = state == UPDATE && render_done_in;
    assign edit_ack_out   = state == EDIT_WR && render_done_in;
    assign upd_rd         = upd_req_in && !upd_we_in && upd_gnt_out;
    assign upd_rvalid_out = rd_pipe[READ_LATENCY-1];
    assign mem_rdata_out  = mem_rdata_in;

    always_ff @(posedge clk_130mhz or posedge rst_in) begin
        if (rst_in) begin
            state <= RENDER;
        end else begin
            state <= state_nxt;
        end
    end

    // Blank ending always wins: any state falls back to RENDER.
    always_comb begin
        state_nxt = RENDER;
        if (render_done_in) begin
            case (state)
                RENDER:    state_nxt = pend ? EDIT_RD : UPDATE;
                EDIT_RD:   state_nxt = READ_LATENCY > 1 ? EDIT_WAIT : EDIT_WR;
                EDIT_WAIT: state_nxt = wait_cnt == WAIT_LAST ? EDIT_WR : EDIT_WAIT;
                default:   state_nxt = UPDATE;
            endcase
        end
    end

    // The RMW works on a snapshot taken at EDIT_RD so that a request arriving
    // mid-edit replaces the slot instead of corrupting the word being written.
    always_ff @(posedge clk_130mhz or posedge rst_in) begin
        if (rst_in) begin
            pend      <= 1'b0;
            renew     <= 1'b0;
            pend_addr <= '0;
            pend_bit  <= '0;
            work_addr <= '0;
            work_bit  <= '0;
            wait_cnt  <= '0;
            rd_pipe   <= '0;
        end else begin
            if (edit_req_in) begin
                pend      <= 1'b1;
                pend_addr <= edit_addr_in;
                pend_bit  <= edit_bit_in;
            end else if (edit_ack_out && !renew) begin
                pend <= 1'b0;
            end
            renew <= state == EDIT_RD ? edit_req_in : renew | edit_req_in;
            if (state == EDIT_RD) begin
                work_addr <= pend_addr;
                work_bit  <= pend_bit;
            end
            wait_cnt <= state == EDIT_WAIT ? wait_cnt + 2'd1 : 2'd0;
            rd_pipe  <= READ_LATENCY'({rd_pipe, upd_rd});
        end
    end

    // EDIT_WR flips the bit in the word arriving on mem_rdata_in this cycle.
    always_comb begin
        mem_addr_out  = render_addr_in;
        mem_we_out    = 1'b0;
        mem_wdata_out = '0;
        if (render_done_in) begin
            case (state)
                EDIT_RD:   mem_addr_out = pend_addr;
                EDIT_WAIT: mem_addr_out = work_addr;
                EDIT_WR: begin
                    mem_addr_out  = work_addr;
                    mem_we_out    = 1'b1;
                    mem_wdata_out = mem_rdata_in ^ (MSB >> work_bit);
                end
                UPDATE: begin
                    mem_addr_out  = upd_addr_in;
                    mem_we_out    = upd_req_in && upd_we_in;
                    mem_wdata_out = upd_wdata_in;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_board_mem_arbiter.sv
// tb_board_mem_arbiter: directed and randomized checks of board_mem_arbiter
// against a 64-word BRAM model with two-cycle read latency and a shadow board.
module tb_board_mem_arbiter;
    logic        clk_130mhz = 1'b0;
    logic        rst_in;
    logic        render_done_in;
    logic [11:0] render_addr_in;
    logic        upd_req_in, upd_we_in;
    logic [11:0] upd_addr_in;
    logic [31:0] upd_wdata_in;
    logic        upd_gnt_out, upd_rvalid_out;
    logic        edit_req_in;
    logic [11:0] edit_addr_in;
    logic [4:0]  edit_bit_in;
    logic        edit_ack_out;
    logic [11:0] mem_addr_out;
    logic        mem_we_out;
    logic [31:0] mem_wdata_out, mem_rdata_in, mem_rdata_out;

    board_mem_arbiter dut (
        .clk_130mhz(clk_130mhz), .rst_in(rst_in),
        .render_done_in(render_done_in), .render_addr_in(render_addr_in),
        .upd_req_in(upd_req_in), .upd_we_in(upd_we_in), .upd_addr_in(upd_addr_in),
        .upd_wdata_in(upd_wdata_in), .upd_gnt_out(upd_gnt_out), .upd_rvalid_out(upd_rvalid_out),
        .edit_req_in(edit_req_in), .edit_addr_in(edit_addr_in), .edit_bit_in(edit_bit_in),
        .edit_ack_out(edit_ack_out), .mem_addr_out(mem_addr_out), .mem_we_out(mem_we_out),
        .mem_wdata_out(mem_wdata_out), .mem_rdata_in(mem_rdata_in), .mem_rdata_out(mem_rdata_out)
    );

    always #5 clk_130mhz = ~clk_130mhz;

    logic [31:0] mem [0:63];
    logic [31:0] model [0:63];
    logic [31:0] p1, p2;
    logic        bd_we = 1'b0;
    logic [5:0]  bd_addr;
    logic [31:0] bd_data;

    always @(posedge clk_130mhz) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (mem_we_out) mem[mem_addr_out[5:0]] <= mem_wdata_out;
        p1 <= mem[mem_addr_out[5:0]];
        p2 <= p1;
    end
    assign mem_rdata_in = p2;

    int n_cmp = 0;
    int n_fail = 0;
    logic        s_gnt, s_rv, s_ack, s_we;
    logic [11:0] s_addr, s_raddr;
    logic [31:0] s_wdata, s_rdata;

    task automatic poke(input logic [5:0] a, input logic [31:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d; model[a] = d;
        @(posedge clk_130mhz); #1;
        bd_we = 1'b0;
    endtask

    task automatic tick(input logic rd, input logic er, input logic [11:0] ea, input logic [4:0] eb,
                        input logic ur, input logic uw, input logic [11:0] ua, input logic [31:0] ud);
        s_raddr = 12'($urandom);
        render_done_in = rd; render_addr_in = s_raddr;
        edit_req_in = er; edit_addr_in = ea; edit_bit_in = eb;
        upd_req_in = ur; upd_we_in = uw; upd_addr_in = ua; upd_wdata_in = ud;
        #3;
        s_gnt = upd_gnt_out; s_rv = upd_rvalid_out; s_ack = edit_ack_out; s_we = mem_we_out;
        s_addr = mem_addr_out; s_wdata = mem_wdata_out; s_rdata = mem_rdata_out;
        @(posedge clk_130mhz); #1;
    endtask

    task automatic idle(input logic rd);
        tick(rd, 1'b0, 12'd0, 5'd0, 1'b0, 1'b0, 12'd0, 32'd0);
    endtask

    task automatic test_reset();
        n_cmp++; if (upd_gnt_out !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %b want 0", upd_gnt_out); end
        n_cmp++; if (upd_rvalid_out !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b want 0", upd_rvalid_out); end
        n_cmp++; if (edit_ack_out !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", edit_ack_out); end
        n_cmp++; if (mem_we_out !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", mem_we_out); end
        rst_in = 1'b0;
        idle(1'b1);
        n_cmp++; if (s_gnt !== 1'b0) begin n_fail++; $display("FAIL first_blank_gnt: got %b want 0", s_gnt); end
        idle(1'b1);
        n_cmp++; if (s_gnt !== 1'b1) begin n_fail++; $display("FAIL update_gnt: got %b want 1", s_gnt); end
        render_done_in = 1'b1; upd_req_in = 1'b1; upd_we_in = 1'b1; upd_addr_in = 12'd10; upd_wdata_in = ~model[10];
        #1;
        n_cmp++; if (mem_we_out !== 1'b1) begin n_fail++; $display("FAIL pre_reset_we: got %b want 1", mem_we_out); end
        rst_in = 1'b1;
        #1;
        n_cmp++; if (mem_we_out !== 1'b0) begin n_fail++; $display("FAIL midreset_we: got %b want 0", mem_we_out); end
        n_cmp++; if (upd_gnt_out !== 1'b0) begin n_fail++; $display("FAIL midreset_gnt: got %b want 0", upd_gnt_out); end
        @(posedge clk_130mhz); #1;
        rst_in = 1'b0;
        #1;
        n_cmp++; if (upd_gnt_out !== 1'b0) begin n_fail++; $display("FAIL post_reset_gnt: got %b want 0", upd_gnt_out); end
        upd_req_in = 1'b0;
        @(posedge clk_130mhz); #1;
        n_cmp++; if (mem[10] !== model[10]) begin n_fail++; $display("FAIL reset_no_write: got %h want %h", mem[10], model[10]); end
    endtask

    task automatic test_render_override();
        idle(1'b1);
        idle(1'b1);
        tick(1'b0, 1'b0, 12'd0, 5'd0, 1'b1, 1'b1, 12'd20, 32'hA5A5_A5A5);
        n_cmp++; if (s_addr !== s_raddr) begin n_fail++; $display("FAIL fall_addr: got %h want %h", s_addr, s_raddr); end
        n_cmp++; if (s_we !== 1'b0) begin n_fail++; $display("FAIL fall_we: got %b want 0", s_we); end
        n_cmp++; if (s_gnt !== 1'b0) begin n_fail++; $display("FAIL fall_gnt: got %b want 0", s_gnt); end
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 1'b0, 12'd0, 5'd0, 1'b1, 1'b1, 12'(20 + i), $urandom);
            n_cmp++; if (s_addr !== s_raddr) begin n_fail++; $display("FAIL render_addr: got %h want %h", s_addr, s_raddr); end
            n_cmp++; if (s_we !== 1'b0 || s_gnt !== 1'b0) begin n_fail++; $display("FAIL render_we_gnt: got we=%b gnt=%b want 0/0", s_we, s_gnt); end
        end
    endtask

    task automatic test_edit_rmw();
        int acks = 0;
        int wes = 0;
        poke(6'd5, 32'h0000_0000);
        tick(1'b0, 1'b1, 12'd5, 5'd0, 1'b0, 1'b0, 12'd0, 32'd0);
        idle(1'b0);
        idle(1'b0);
        for (int k = 0; k < 6; k++) begin
            idle(1'b1);
            acks += int'(s_ack); wes += int'(s_we);
            if (k == 1) begin
                n_cmp++; if (s_addr !== 12'd5 || s_we !== 1'b0) begin n_fail++; $display("FAIL edit_read: got addr=%h we=%b want 005/0", s_addr, s_we); end
            end
            if (k == 3) begin
                n_cmp++; if (s_we !== 1'b1 || s_addr !== 12'd5) begin n_fail++; $display("FAIL edit_write: got addr=%h we=%b want 005/1", s_addr, s_we); end
                n_cmp++; if (s_wdata !== 32'h8000_0000) begin n_fail++; $display("FAIL edit_wdata: got %h want 80000000", s_wdata); end
                n_cmp++; if (s_ack !== 1'b1) begin n_fail++; $display("FAIL edit_ack: got %b want 1", s_ack); end
            end
        end
        model[5] = 32'h8000_0000;
        n_cmp++; if (acks != 1 || wes != 1) begin n_fail++; $display("FAIL edit_counts: got acks=%0d writes=%0d want 1/1", acks, wes); end
        idle(1'b0);
        n_cmp++; if (mem[5] !== model[5]) begin n_fail++; $display("FAIL edit_mem: got %h want %h", mem[5], model[5]); end
    endtask

    task automatic test_update_read();
        logic [31:0] v = $urandom;
        poke(6'd9, v);
        idle(1'b1);
        n_cmp++; if (s_gnt !== 1'b0) begin n_fail++; $display("FAIL rise_gnt: got %b want 0", s_gnt); end
        tick(1'b1, 1'b0, 12'd0, 5'd0, 1'b1, 1'b0, 12'd9, 32'd0);
        n_cmp++; if (s_gnt !== 1'b1 || s_addr !== 12'd9) begin n_fail++; $display("FAIL upd_issue: got gnt=%b addr=%h want 1/009", s_gnt, s_addr); end
        idle(1'b1);
        n_cmp++; if (s_rv !== 1'b0) begin n_fail++; $display("FAIL rvalid_early: got %b want 0", s_rv); end
        idle(1'b1);
        n_cmp++; if (s_rv !== 1'b1) begin n_fail++; $display("FAIL rvalid: got %b want 1", s_rv); end
        n_cmp++; if (s_rdata !== v) begin n_fail++; $display("FAIL rdata: got %h want %h", s_rdata, v); end
        idle(1'b1);
        n_cmp++; if (s_rv !== 1'b0) begin n_fail++; $display("FAIL rvalid_late: got %b want 0", s_rv); end
        idle(1'b0);
    endtask

    task automatic test_edit_abort();
        logic [31:0] v = $urandom;
        int acks = 0;
        int wes = 0;
        poke(6'd12, v);
        tick(1'b0, 1'b1, 12'd12, 5'd7, 1'b0, 1'b0, 12'd0, 32'd0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);
        n_cmp++; if (s_addr !== 12'd12) begin n_fail++; $display("FAIL abort_read: got %h want 00c", s_addr); end
        for (int k = 0; k < 4; k++) begin
            idle(1'b0);
            acks += int'(s_ack); wes += int'(s_we);
        end
        n_cmp++; if (acks != 0 || wes != 0) begin n_fail++; $display("FAIL abort_quiet: got acks=%0d writes=%0d want 0/0", acks, wes); end
        for (int k = 0; k < 6; k++) begin
            idle(1'b1);
            acks += int'(s_ack);
            if (k == 3) begin
                n_cmp++; if (s_ack !== 1'b1 || s_wdata !== (v ^ 32'h0100_0000)) begin n_fail++; $display("FAIL retry_write: got ack=%b data=%h want 1/%h", s_ack, s_wdata, v ^ 32'h0100_0000); end
            end
        end
        model[12] = v ^ 32'h0100_0000;
        idle(1'b0);
        n_cmp++; if (acks != 1 || mem[12] !== model[12]) begin n_fail++; $display("FAIL retry_mem: got acks=%0d mem=%h want 1/%h", acks, mem[12], model[12]); end
    endtask

    task automatic test_last_edit_wins();
        logic [4:0] b1 = 5'($urandom);
        logic [4:0] b2 = 5'($urandom);
        int acks = 0;
        poke(6'd3, $urandom);
        poke(6'd7, $urandom);
        tick(1'b0, 1'b1, 12'd3, b1, 1'b0, 1'b0, 12'd0, 32'd0);
        idle(1'b0);
        tick(1'b0, 1'b1, 12'd7, b2, 1'b0, 1'b0, 12'd0, 32'd0);
        idle(1'b0);
        for (int k = 0; k < 6; k++) begin
            idle(1'b1);
            acks += int'(s_ack);
            if (k == 3) begin
                n_cmp++; if (s_addr !== 12'd7 || s_we !== 1'b1) begin n_fail++; $display("FAIL last_edit_addr: got addr=%h we=%b want 007/1", s_addr, s_we); end
            end
        end
        model[7] = model[7] ^ (32'h8000_0000 >> b2);
        idle(1'b0);
        n_cmp++; if (acks != 1) begin n_fail++; $display("FAIL last_edit_acks: got %0d want 1", acks); end
        n_cmp++; if (mem[3] !== model[3] || mem[7] !== model[7]) begin n_fail++; $display("FAIL last_edit_mem: got %h/%h want %h/%h", mem[3], mem[7], model[3], model[7]); end
    endtask

    // Timeline model: with a pending edit the toggle lands on the 4th blank
    // cycle and the updater owns the port afterwards; otherwise from the 2nd.
    task automatic test_random();
        logic pend, had, blank, er, ur, uw, g_exp, a_exp, rv_exp;
        logic [11:0] pa, ea, ua;
        logic [4:0] pb, eb;
        logic [31:0] ud;
        int rl, bl, now, j;
        int due[$];
        logic [31:0] exp_d[$];
        pend = 1'b0; had = 1'b0; pa = '0; pb = '0; now = 0;
        for (int f = 0; f < 60; f++) begin
            rl = $urandom_range(2, 6);
            bl = $urandom_range(1, 10);
            for (int k = 0; k < rl + bl + (f == 59 ? 3 : 0); k++) begin
                blank = k >= rl && k < rl + bl;
                j = k - rl;
                if (j == 0) had = pend;
                er = !blank && k < rl && $urandom_range(0, 2) == 0;
                ea = 12'($urandom_range(0, 63)); eb = 5'($urandom);
                g_exp = blank && (had ? j >= 4 : j >= 1);
                a_exp = blank && had && j == 3;
                ur = 1'($urandom_range(0, 1)); uw = 1'($urandom_range(0, 1));
                ua = 12'($urandom_range(0, 63)); ud = $urandom;
                tick(blank, er, ea, eb, ur, uw, ua, ud);
                rv_exp = due.size() > 0 && due[0] == now;
                n_cmp++; if (s_gnt !== g_exp) begin n_fail++; $display("FAIL rnd_gnt t=%0d: got %b want %b", now, s_gnt, g_exp); end
                n_cmp++; if (s_ack !== a_exp) begin n_fail++; $display("FAIL rnd_ack t=%0d: got %b want %b", now, s_ack, a_exp); end
                n_cmp++; if (s_rv !== rv_exp) begin n_fail++; $display("FAIL rnd_rvalid t=%0d: got %b want %b", now, s_rv, rv_exp); end
                if (rv_exp) begin
                    n_cmp++; if (s_rdata !== exp_d[0]) begin n_fail++; $display("FAIL rnd_rdata t=%0d: got %h want %h", now, s_rdata, exp_d[0]); end
                    void'(due.pop_front()); void'(exp_d.pop_front());
                end
                if (!blank) begin
                    n_cmp++; if (s_addr !== s_raddr || s_we !== 1'b0) begin n_fail++; $display("FAIL rnd_render t=%0d: got addr=%h we=%b want %h/0", now, s_addr, s_we, s_raddr); end
                end
                if (g_exp) begin
                    n_cmp++; if (s_we !== (ur & uw)) begin n_fail++; $display("FAIL rnd_upd_we t=%0d: got %b want %b", now, s_we, ur & uw); end
                end
                if (er) begin pend = 1'b1; pa = ea; pb = eb; end
                if (a_exp) begin model[pa[5:0]] = model[pa[5:0]] ^ (32'h8000_0000 >> pb); pend = 1'b0; end
                if (g_exp && ur && uw) model[ua[5:0]] = ud;
                if (g_exp && ur && !uw) begin due.push_back(now + 2); exp_d.push_back(model[ua[5:0]]); end
                now++;
            end
        end
        n_cmp++; if (due.size() != 0) begin n_fail++; $display("FAIL rnd_lost_reads: got %0d outstanding want 0", due.size()); end
    endtask

    task automatic test_memory();
        for (int i = 0; i < 64; i++) begin
            n_cmp++; if (mem[i] !== model[i]) begin n_fail++; $display("FAIL board_word %0d: got %h want %h", i, mem[i], model[i]); end
        end
    endtask

    initial begin
        rst_in = 1'b1; render_done_in = 1'b1; render_addr_in = '0;
        upd_req_in = 1'b1; upd_we_in = 1'b1; upd_addr_in = 12'd10; upd_wdata_in = 32'hDEAD_BEEF;
        edit_req_in = 1'b0; edit_addr_in = '0; edit_bit_in = '0;
        @(posedge clk_130mhz); #1;
        for (int i = 0; i < 64; i++) poke(6'(i), $urandom);
        test_reset();
        test_render_override();
        test_edit_rmw();
        test_update_read();
        test_edit_abort();
        test_last_edit_wins();
        test_random();
        test_memory();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
